// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the CNN floating-point datapath
// (fp_mul_pipe today, fp_add revisions later).
package fp_pkg;

    localparam int unsigned FP_BIAS    = 127;
    localparam int unsigned FP_EXP_MAX = 255;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] frac;      // hidden bit included
        logic        is_zero;
        logic        is_inf;
        logic        is_nan;
    } fp_unpacked_t;

    // Resolved operand-pair class, already in special-case priority order.
    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    // Denormals are flushed to zero: any word with a zero exponent is classed as zero.
    function automatic fp_unpacked_t fp_unpack_word(input logic [31:0] word);
        fp_unpacked_t u;
        u.sign    = word[31];
        u.exp     = word[30:23];
        u.frac    = {1'b1, word[22:0]};
        u.is_zero = (word[30:23] == 8'd0);
        u.is_inf  = (word[30:23] == 8'(FP_EXP_MAX)) && (word[22:0] == 23'd0);
        u.is_nan  = (word[30:23] == 8'(FP_EXP_MAX)) && (word[22:0] != 23'd0);
        return u;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational operand classifier: splits one IEEE-754 single into fields
// and zero/inf/nan flags.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0] word,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [23:0] frac,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);

    fp_unpacked_t u;

    assign u       = fp_unpack_word(word);
    assign sign    = u.sign;
    assign exp     = u.exp;
    assign frac    = u.frac;
    assign is_zero = u.is_zero;
    assign is_inf  = u.is_inf;
    assign is_nan  = u.is_nan;

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined single-precision multiplier (unpack, multiply, normalize/pack)
// with valid/ready flow control and a pass-through sideband tag.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int TAG_W         = 1,
    parameter int ROUND_NEAREST = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a_fp,
    input  logic [31:0]      b_fp,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [7:0]       exponent,
    output logic [22:0]      mantissa,
    output logic [TAG_W-1:0] out_tag
);

    logic advance;

    // The whole pipe freezes together while the output register is held.
    assign advance  = ~(out_valid & ~out_ready);
    assign in_ready = advance;

    // ---------------------------------------------------------------- S1 unpack
    logic        ua_sign, ub_sign;
    logic [7:0]  ua_exp, ub_exp;
    logic [23:0] ua_frac, ub_frac;
    logic        ua_zero, ub_zero, ua_inf, ub_inf, ua_nan, ub_nan;

    fp_unpack u_unpack_a (
        .word    (a_fp),
        .sign    (ua_sign),
        .exp     (ua_exp),
        .frac    (ua_frac),
        .is_zero (ua_zero),
        .is_inf  (ua_inf),
        .is_nan  (ua_nan)
    );

    fp_unpack u_unpack_b (
        .word    (b_fp),
        .sign    (ub_sign),
        .exp     (ub_exp),
        .frac    (ub_frac),
        .is_zero (ub_zero),
        .is_inf  (ub_inf),
        .is_nan  (ub_nan)
    );

    logic signed [9:0] esum_c;
    fp_class_e         class_c;

    assign esum_c = $signed({2'b00, ua_exp}) + $signed({2'b00, ub_exp}) - $signed(10'(FP_BIAS));

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves class_c unassigned (no latch).
        class_c = CLS_NORMAL;
        if (ua_nan || ub_nan || (ua_inf && ub_zero) || (ua_zero && ub_inf)) begin
            class_c = CLS_NAN;
        end else if (ua_inf || ub_inf) begin
            class_c = CLS_INF;
        end else if (ua_zero || ub_zero) begin
            class_c = CLS_ZERO;
        end
    end

    // ---------------------------------------------------------------- stage registers
    logic              s1_valid, s2_valid;
    logic              s1_sign, s2_sign;
    logic signed [9:0] s1_esum, s2_esum;
    logic [23:0]       s1_fa, s1_fb;
    logic [47:0]       s2_prod;
    fp_class_e         s1_class, s2_class;
    logic [TAG_W-1:0]  s1_tag, s2_tag;

    logic              res_sign;
    logic [7:0]        res_exp;
    logic [22:0]       res_man;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            sign      <= 1'b0;
            exponent  <= 8'd0;
            mantissa  <= 23'd0;
            out_tag   <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                sign     <= res_sign;
                exponent <= res_exp;
                mantissa <= res_man;
                out_tag  <= s2_tag;
            end
        end
    end

    // NOTE: payload registers carry no reset; the valid bits alone decide whether they mean anything.
    always_ff @(posedge clock) begin
        if (advance) begin
            s1_sign  <= ua_sign ^ ub_sign;
            s1_esum  <= esum_c;
            s1_fa    <= ua_frac;
            s1_fb    <= ub_frac;
            s1_class <= class_c;
            s1_tag   <= in_tag;

            s2_sign  <= s1_sign;
            s2_esum  <= s1_esum;
            s2_prod  <= {24'd0, s1_fa} * {24'd0, s1_fb};
            s2_class <= s1_class;
            s2_tag   <= s1_tag;
        end
    end

    // ---------------------------------------------------------------- S3 normalize / round / pack
    logic [22:0]       m_trunc;
    logic              guard_bit, sticky_bit, round_up;
    logic [23:0]       m_round;
    logic signed [9:0] e_norm, e_final;

    always_comb begin
        m_trunc    = s2_prod[45:23];
        guard_bit  = s2_prod[22];
        sticky_bit = |s2_prod[21:0];
        e_norm     = s2_esum;
        if (s2_prod[47]) begin
            m_trunc    = s2_prod[46:24];
            guard_bit  = s2_prod[23];
            sticky_bit = |s2_prod[22:0];
            e_norm     = s2_esum + 10'sd1;
        end

        // Ties go to even; a carry out of the fraction wraps it to 1.0 and bumps the exponent.
        round_up = (ROUND_NEAREST != 0) && guard_bit && (sticky_bit || m_trunc[0]);
        m_round  = {1'b0, m_trunc} + {23'd0, round_up};
        e_final  = m_round[23] ? e_norm + 10'sd1 : e_norm;

        res_sign = s2_sign;
        res_exp  = e_final[7:0];
        res_man  = m_round[22:0];

        case (s2_class)
            CLS_NAN: begin
                res_sign = FP_QNAN[31];
                res_exp  = FP_QNAN[30:23];
                res_man  = FP_QNAN[22:0];
            end
            CLS_INF: begin
                res_exp = 8'(FP_EXP_MAX);
                res_man = 23'd0;
            end
            CLS_ZERO: begin
                res_exp = 8'd0;
                res_man = 23'd0;
            end
            default: begin
                if (e_final >= $signed(10'(FP_EXP_MAX))) begin
                    res_exp = 8'(FP_EXP_MAX);
                    res_man = 23'd0;
                end else if (e_final <= 10'sd0) begin
                    res_exp = 8'd0;
                    res_man = 23'd0;
                end
            end
        endcase
    end

endmodule
